vga_bus_bridge: RTL and testbench
=================================

// Module: vga_bus_bridge
// PURPOSE
//  CPU-side front end of the VGA subsystem; sits directly upstream of vga_controller.
//  Decodes single CPU MMIO accesses into its text/graph/cursor/reg strobe groups.
//  Posts writes through a small FIFO that drains only while the scan-out port is not busy.
//  Stalls reads until all earlier writes have drained, preserving program order.
// PARAMETERS
//  DEPTH     4  posted-write FIFO entries (power of two, >=2)
//  READ_LAT  1  cycles from rd_* pulse to valid *_rdata at vga_controller
//  HOLD_BUSY 1  1: drain only when vga_busy==0; 0: ignore vga_busy
// PORTS
//  clk           in   1   system clock (same clock as vga_controller clk)
//  rst           in   1   asynchronous, active-low reset (0 = reset)
//  cpu_req       in   1   access request; held stable until cpu_ready
//  cpu_we        in   1   1 = write, 0 = read
//  cpu_be        in   4   byte enables (writes only)
//  cpu_addr      in   32  byte address; [21:20] region: 00 text, 01 graph, 10 cursor, 11 reg
//  cpu_wdata     in   32  write data
//  cpu_ready     out  1   access complete this cycle
//  cpu_rdata     out  32  read data, valid when cpu_ready && !cpu_we
//  vga_busy      in   1   vga_controller busy (scan-out reading)
//  we_text/we_graph/we_cursor/we_reg  out 4 byte write strobes, one-cycle pulses
//  rd_text/rd_graph/rd_cursor/rd_reg  out 1 read strobes, one-cycle pulses
//  text_addr, graph_addr        out 32  address of current access (cpu_addr[31:0])
//  text_wdata, graph_wdata, cursor_wdata, reg_wdata  out 32  drained write data
//  text_rdata, graph_rdata, cursor_rdata, reg_rdata  in  32  read data from controller
// BEHAVIOUR
//  Reset: FIFO empty, FSM IDLE, all we_*=0, rd_*=0, cpu_ready=0, cpu_rdata=0, addr/wdata=0.
//  Reset mid-operation discards all queued writes and any read in flight; no strobe is emitted.
//  Write accept: cpu_req && cpu_we && !full -> push {region,addr,be,wdata}; cpu_ready=1 same cycle.
//   Full: cpu_ready=0, CPU stalls; no bypass of a full FIFO even if a pop happens that cycle.
//  Drain: when FIFO non-empty && (!HOLD_BUSY || !vga_busy): pop head; next cycle the selected
//   we_<region>=be for exactly one cycle, with the matching addr/wdata driven. One pop per cycle.
//   Push and pop in the same cycle are legal when not full; count unchanged.
//  Read FSM: IDLE -> (cpu_req && !cpu_we && FIFO empty && no drain pulse pending) RD_ISSUE
//   RD_ISSUE: rd_<region>=1, addr driven, one cycle -> RD_WAIT
//   RD_WAIT: count READ_LAT cycles, then capture <region>_rdata into cpu_rdata -> RD_DONE
//   RD_DONE: cpu_ready=1 for one cycle -> IDLE. Read latency = READ_LAT+3 cycles from empty FIFO.
//  Reads ignore vga_busy; reads queued behind writes wait in IDLE (cpu_ready=0).
//  While FSM is not IDLE no write is accepted (single outstanding CPU access).
//  Strobe groups are mutually exclusive; at most one we_* or rd_* group active per cycle.
//  Pointers are log2(DEPTH)+1 bits; full/empty by MSB compare; wrap-around is natural.
// STRUCTURE
//  Shared package vga_pkg: region codes (REG_TEXT=2'b00, REG_GRAPH=2'b01, REG_CURSOR=2'b10,
//   REG_REG=2'b11), region field position [21:20], FSM state encodings.
//  One sub-module: vga_wbuf (synchronous FIFO, 70-bit entries, parameter DEPTH, full/empty).
//  Top holds decode, read FSM, strobe/output registers and rdata mux.
// TESTING
//  Write 0x0000_0010 be=F data=0xA5A5A5A5, busy=0 -> ready same cycle; next cycle we_text=F once.
//  5 back-to-back writes, busy=1 -> first 4 ready, 5th stalls; busy=0 -> 4 pops in 4 cycles, 5th accepted.
//  Write graph 0x0010_0004 then read it, busy=1 for 10 cycles -> rd_graph only after we_graph pulse.
//  Read reg 0x0030_0000 with reg_rdata=0x0001_0003, FIFO empty -> cpu_ready at cycle 4, rdata match.
//  Assert rst low with 3 writes queued and read in RD_WAIT -> all outputs 0, no strobes after release.
//  Push+pop same cycle at count=3 -> count stays 3, data order preserved across pointer wrap.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared definitions for the VGA bus bridge. Holds the region
//                codes decoded from cpu_addr[21:20], the layout of one
//                posted-write FIFO entry, and the read FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Region codes carried in cpu_addr[REGION_MSB:REGION_LSB]
    localparam logic [1:0] REG_TEXT   = 2'b00;
    localparam logic [1:0] REG_GRAPH  = 2'b01;
    localparam logic [1:0] REG_CURSOR = 2'b10;
    localparam logic [1:0] REG_REG    = 2'b11;

    localparam int REGION_LSB = 20;
    localparam int REGION_MSB = 21;

    // One posted write: region + address + byte enables + data = 70 bits
    localparam int ENTRY_W = 70;

    typedef struct packed {
        logic [1:0]  region;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_DONE  = 2'd3
    } rd_state_t;

    // One-hot read strobe vector ordered {text, graph, cursor, reg}
    function automatic logic [3:0] region_onehot(input logic [1:0] region);
        return 4'b1000 >> region;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_wbuf.sv
`default_nettype none
// ============================================================================
//  Module      : vga_wbuf
//  Description : Synchronous posted-write FIFO. Pointers carry one extra wrap
//                bit so full/empty are told apart by the MSB comparison.
//                Head entry is presented combinationally on pop_data.
//  Ports       : clk, rst (async, active-low)
//                push, push_data  - write side (ignored while full)
//                pop, pop_data    - read side (ignored while empty)
//                full, empty      - occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module vga_wbuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-2:0]] <= push_data;
    end

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                      (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
    assign pop_data = r_mem[r_rd_ptr[PTR_W-2:0]];

endmodule
`default_nettype wire

// File: rtl/vga_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : vga_bus_bridge
//  Description : CPU-side front end of the VGA subsystem. Posts CPU writes
//                into a small FIFO that drains into one-cycle byte-write
//                strobes while the scan-out port is idle; reads wait until
//                every earlier write has drained, then issue a one-cycle
//                read strobe and return the selected region's data.
//  Ports       : clk, rst (async, active-low)
//                cpu_req/we/be/addr/wdata -> cpu_ready, cpu_rdata
//                vga_busy                  scan-out busy, holds off draining
//                we_* / rd_*               per-region write/read strobes
//                text_addr, graph_addr     address of the current access
//                *_wdata                   drained write data
//                *_rdata                   read data from vga_controller
//  Revision    : 1.0  initial release
// ============================================================================
module vga_bus_bridge
    import vga_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int READ_LAT  = 1,
    parameter int HOLD_BUSY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        vga_busy,
    output logic [3:0]  we_text,
    output logic [3:0]  we_graph,
    output logic [3:0]  we_cursor,
    output logic [3:0]  we_reg,
    output logic        rd_text,
    output logic        rd_graph,
    output logic        rd_cursor,
    output logic        rd_reg,
    output logic [31:0] text_addr,
    output logic [31:0] graph_addr,
    output logic [31:0] text_wdata,
    output logic [31:0] graph_wdata,
    output logic [31:0] cursor_wdata,
    output logic [31:0] reg_wdata,
    input  logic [31:0] text_rdata,
    input  logic [31:0] graph_rdata,
    input  logic [31:0] cursor_rdata,
    input  logic [31:0] reg_rdata
);

    localparam int CNT_W = $clog2(READ_LAT + 1) + 1;

    rd_state_t        r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [1:0]       r_rd_region;
    logic [31:0]      r_cpu_rdata;
    logic [3:0]       r_we_text;
    logic [3:0]       r_we_graph;
    logic [3:0]       r_we_cursor;
    logic [3:0]       r_we_reg;
    logic [3:0]       r_rd_vec;      // {text, graph, cursor, reg}
    logic             r_drain_vld;   // a drain strobe is on the outputs now
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_start;
    logic [1:0]         w_cpu_region;
    logic [ENTRY_W-1:0] w_head_bits;
    wbuf_entry_t        w_head;
    wbuf_entry_t        w_new_entry;
    logic [31:0]        w_rd_mux;

    assign w_cpu_region = cpu_addr[REGION_MSB:REGION_LSB];

    assign w_new_entry = '{region: w_cpu_region, addr: cpu_addr,
                           be: cpu_be, wdata: cpu_wdata};
    assign w_head = wbuf_entry_t'(w_head_bits);

    // Writes are only accepted with no read outstanding; a full FIFO stalls
    // the CPU even when the head is popped in the same cycle.
    assign w_push = rst && cpu_req && cpu_we && !w_full && (r_state == ST_IDLE);
    assign w_pop  = !w_empty && ((HOLD_BUSY == 0) || !vga_busy);

    // A read starts only once the FIFO is empty and the last drained write
    // has left the strobe outputs, so program order is kept at the port.
    assign w_rd_start = (r_state == ST_IDLE) && cpu_req && !cpu_we &&
                        w_empty && !r_drain_vld;

    vga_wbuf #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_new_entry),
        .pop       (w_pop),
        .pop_data  (w_head_bits),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_rd_mux = text_rdata;
        case (r_rd_region)
            REG_GRAPH:  w_rd_mux = graph_rdata;
            REG_CURSOR: w_rd_mux = cursor_rdata;
            REG_REG:    w_rd_mux = reg_rdata;
            default:    w_rd_mux = text_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_rd_region <= REG_TEXT;
            r_cpu_rdata <= '0;
            r_we_text   <= '0;
            r_we_graph  <= '0;
            r_we_cursor <= '0;
            r_we_reg    <= '0;
            r_rd_vec    <= '0;
            r_drain_vld <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            // Strobes are single-cycle pulses by default
            r_we_text   <= '0;
            r_we_graph  <= '0;
            r_we_cursor <= '0;
            r_we_reg    <= '0;
            r_rd_vec    <= '0;
            r_drain_vld <= w_pop;

            if (w_pop) begin
                r_addr  <= w_head.addr;
                r_wdata <= w_head.wdata;
                case (w_head.region)
                    REG_GRAPH:  r_we_graph  <= w_head.be;
                    REG_CURSOR: r_we_cursor <= w_head.be;
                    REG_REG:    r_we_reg    <= w_head.be;
                    default:    r_we_text   <= w_head.be;
                endcase
            end

            // Pops never coincide with a read start or an outstanding read,
            // since the FIFO is empty then and no write can be accepted.
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_start) begin
                        r_state     <= ST_RD_ISSUE;
                        r_rd_region <= w_cpu_region;
                        r_addr      <= cpu_addr;
                        r_rd_vec    <= region_onehot(w_cpu_region);
                        r_wait_cnt  <= '0;
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (r_wait_cnt == CNT_W'(READ_LAT)) begin
                        r_cpu_rdata <= w_rd_mux;
                        r_state     <= ST_RD_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_RD_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready    = w_push || (rst && (r_state == ST_RD_DONE));
    assign cpu_rdata    = r_cpu_rdata;
    assign we_text      = r_we_text;
    assign we_graph     = r_we_graph;
    assign we_cursor    = r_we_cursor;
    assign we_reg       = r_we_reg;
    assign rd_text      = r_rd_vec[3];
    assign rd_graph     = r_rd_vec[2];
    assign rd_cursor    = r_rd_vec[1];
    assign rd_reg       = r_rd_vec[0];
    assign text_addr    = r_addr;
    assign graph_addr   = r_addr;
    assign text_wdata   = r_wdata;
    assign graph_wdata  = r_wdata;
    assign cursor_wdata = r_wdata;
    assign reg_wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_bus_bridge
//  Description : Self-checking bench for vga_bus_bridge. A cycle-level
//                reference model (FIFO occupancy count, program-ordered queue
//                of posted writes, single outstanding read) predicts ready,
//                strobes, addresses, write data and read data each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_bus_bridge;

    localparam int DEPTH    = 4;
    localparam int READ_LAT = 1;

    typedef struct packed {
        logic [1:0]  region;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        vga_busy = 1'b0;
    logic [3:0]  we_text, we_graph, we_cursor, we_reg;
    logic        rd_text, rd_graph, rd_cursor, rd_reg;
    logic [31:0] text_addr, graph_addr;
    logic [31:0] text_wdata, graph_wdata, cursor_wdata, reg_wdata;
    logic [31:0] rdata_arr [4];

    int n_tests = 0;
    int n_fail  = 0;
    int busy_mode = 0;   // 0: idle, 1: busy, 2: random

    vga_bus_bridge #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .HOLD_BUSY(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .vga_busy(vga_busy),
        .we_text(we_text), .we_graph(we_graph), .we_cursor(we_cursor), .we_reg(we_reg),
        .rd_text(rd_text), .rd_graph(rd_graph), .rd_cursor(rd_cursor), .rd_reg(rd_reg),
        .text_addr(text_addr), .graph_addr(graph_addr),
        .text_wdata(text_wdata), .graph_wdata(graph_wdata),
        .cursor_wdata(cursor_wdata), .reg_wdata(reg_wdata),
        .text_rdata(rdata_arr[0]), .graph_rdata(rdata_arr[1]),
        .cursor_rdata(rdata_arr[2]), .reg_rdata(rdata_arr[3])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sole driver of vga_busy; updated mid-cycle so it is stable at negedge.
    always @(posedge clk) begin
        #2;
        case (busy_mode)
            0:       vga_busy = 1'b0;
            1:       vga_busy = 1'b1;
            default: vga_busy = ($urandom_range(0, 9) < 4);
        endcase
    end

    // ---------------- reference model, evaluated every negedge ----------------
    wr_t         wq[$];
    wr_t         m_e;
    int          m_count    = 0;
    bit          m_pop_prev = 0;
    bit          m_rd_act   = 0;
    int          m_rd_issue, m_rd_ready;
    logic [1:0]  m_rd_region;
    logic [31:0] m_rd_addr;
    int          cyc = 0;
    logic [15:0] exp_we;
    logic [3:0]  exp_rd;
    logic [31:0] sel_wd;
    bit          push_now, pop_now, exp_ready, rd_done;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rst_ctl", 128'({cpu_ready, cpu_rdata, we_text, we_graph, we_cursor, we_reg,
                                 rd_text, rd_graph, rd_cursor, rd_reg}), 128'(0));
            chk("rst_addr", 128'({text_addr, graph_addr}), 128'(0));
            chk("rst_wdata", {text_wdata, graph_wdata, cursor_wdata, reg_wdata}, 128'(0));
            wq.delete();
            m_count = 0; m_pop_prev = 0; m_rd_act = 0;
        end else begin
            // Drain strobe expected from a pop one cycle earlier
            exp_we = '0;
            if (m_pop_prev) begin
                m_e = wq.pop_front();
                exp_we = 16'(m_e.be) << (4 * (3 - int'(m_e.region)));
            end
            chk("we", 128'({we_text, we_graph, we_cursor, we_reg}), 128'(exp_we));
            if (m_pop_prev) begin
                case (m_e.region)
                    2'd0: sel_wd = text_wdata;
                    2'd1: sel_wd = graph_wdata;
                    2'd2: sel_wd = cursor_wdata;
                    default: sel_wd = reg_wdata;
                endcase
                chk("wr_addr_data", 128'({text_addr, graph_addr, sel_wd}),
                    128'({m_e.addr, m_e.addr, m_e.wdata}));
            end

            exp_rd = (m_rd_act && cyc == m_rd_issue) ? (4'b1000 >> m_rd_region) : 4'b0000;
            chk("rd", 128'({rd_text, rd_graph, rd_cursor, rd_reg}), 128'(exp_rd));
            if (exp_rd != 0)
                chk("rd_addr", 128'({text_addr, graph_addr}), 128'({m_rd_addr, m_rd_addr}));

            pop_now  = (m_count > 0) && !vga_busy;
            push_now = cpu_req && cpu_we && !m_rd_act && (m_count < DEPTH);
            if (!m_rd_act && cpu_req && !cpu_we && m_count == 0 && !m_pop_prev) begin
                m_rd_act    = 1;
                m_rd_issue  = cyc + 1;
                m_rd_ready  = cyc + READ_LAT + 3;
                m_rd_region = cpu_addr[21:20];
                m_rd_addr   = cpu_addr;
            end
            rd_done   = m_rd_act && (cyc == m_rd_ready);
            exp_ready = push_now || rd_done;
            chk("ready", 128'(cpu_ready), 128'(exp_ready));
            if (rd_done) begin
                chk("rdata", 128'(cpu_rdata), 128'(rdata_arr[m_rd_region]));
                m_rd_act = 0;
            end

            if (push_now) wq.push_back('{cpu_addr[21:20], cpu_addr, cpu_be, cpu_wdata});
            m_count    = m_count + int'(push_now) - int'(pop_now);
            m_pop_prev = pop_now;
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 after the access completes.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = data;
        lat = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) break;
            lat++;
            if (lat > 100) begin
                chk("ready_timeout", 128'(cpu_ready), 128'(1));
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int lat, lat5;
    logic        rw;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 4; i++) rdata_arr[i] = '0;
        idle(3);
        rst = 1'b1;
        idle(2);

        // Single text write, scan-out idle
        access(1'b1, 32'h0000_0010, 4'hF, 32'hA5A5A5A5, lat);
        chk("t1_lat", 128'(lat), 128'(0));
        @(negedge clk); chk("t1_we_pop", 128'(we_text), 128'(0));
        @(negedge clk); chk("t1_we_text", 128'(we_text), 128'(4'hF));
        @(negedge clk); chk("t1_we_once", 128'(we_text), 128'(0));
        idle(4);

        // Fill to DEPTH while busy, fifth write stalls until drain starts
        busy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 32'h0010_0000 + 32'(i * 4), 4'(i + 1), $urandom, lat);
            chk("fill_lat", 128'(lat), 128'(0));
        end
        fork
            access(1'b1, 32'h0020_0040, 4'h3, 32'h5555_AAAA, lat5);
            begin idle(5); busy_mode = 0; end
        join
        chk("stall_lat", 128'(lat5), 128'(6));
        idle(8);

        // Read after write to graph, held behind a busy scan-out
        busy_mode = 1;
        access(1'b1, 32'h0010_0004, 4'hC, 32'hDEAD_BEEF, lat);
        for (int i = 0; i < 4; i++) rdata_arr[i] = $urandom;
        fork
            access(1'b0, 32'h0010_0004, 4'h0, 32'h0, lat);
            begin idle(10); busy_mode = 0; end
        join
        chk("rd_after_wr_lat", 128'(lat), 128'(16));
        idle(4);

        // Register read from an empty FIFO
        rdata_arr[3] = 32'h0001_0003;
        access(1'b0, 32'h0030_0000, 4'h0, 32'h0, lat);
        chk("rd_reg_lat", 128'(lat), 128'(READ_LAT + 3));
        chk("rd_reg_data", 128'(cpu_rdata), 128'(32'h0001_0003));
        idle(3);

        // Push and pop in the same cycle at count 3, across the pointer wrap
        busy_mode = 1;
        for (int i = 0; i < 3; i++) access(1'b1, 32'h0000_0100 + 32'(i), 4'hF, $urandom, lat);
        busy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 32'h0020_0200 + 32'(i), 4'h5, $urandom, lat);
            chk("pushpop_lat", 128'(lat), 128'(0));
        end
        idle(8);

        // Reset with writes queued
        busy_mode = 1;
        for (int i = 0; i < 3; i++) access(1'b1, 32'h0030_0010 + 32'(i), 4'hA, $urandom, lat);
        rst = 1'b0;
        idle(2);
        busy_mode = 0;
        rst = 1'b1;
        idle(8);

        // Reset with a read waiting for data
        rdata_arr[1] = 32'h1234_5678;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0010_0008;
        idle(2);
        rst = 1'b0; cpu_req = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(8);

        // Randomized mix of reads and writes with a random busy pattern
        busy_mode = 2;
        for (int k = 0; k < 250; k++) begin
            rw = ($urandom_range(0, 9) < 6);
            ra = $urandom;
            ra[21:20] = 2'($urandom_range(0, 3));
            if (!rw) for (int i = 0; i < 4; i++) rdata_arr[i] = $urandom;
            access(rw, ra, 4'($urandom_range(1, 15)), $urandom, lat);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        busy_mode = 0;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
